// File: rtl/btn_counter_pkg.sv
// btn_counter shared types and constants.
// Optional feature macro: BTN_COUNTER_AUTOREPEAT_EN.
package btn_counter_pkg;

  localparam int SYNC_STAGES = 2;

  // 10 ms settle time at 50 MHz.
  localparam int DEF_DEBOUNCE = 500000;

  typedef enum logic [1:0] {
    EV_NONE,
    EV_UP,
    EV_DOWN,
    EV_CLR
  } ev_e;

  // Clear wins; simultaneous up and down cancel.
  function automatic ev_e resolve_ev(
    input logic up,
    input logic dn,
    input logic clr
  );
    ev_e ev;
    ev = EV_NONE;
    if (clr) begin
      ev = EV_CLR;
    end else if (up && !dn) begin
      ev = EV_UP;
    end else if (dn && !up) begin
      ev = EV_DOWN;
    end
    return ev;
  endfunction

  // Bits needed for a counter holding 0 .. n-1.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/btn_counter_debounce.sv
// One button: synchroniser, debounce, press pulse.
// Repeat timer present only with BTN_COUNTER_AUTOREPEAT_EN.
module btn_debounce
  import btn_counter_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE
`ifdef BTN_COUNTER_AUTOREPEAT_EN
  ,
  parameter bit REPEAT_EN     = 1'b1,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_press
);

  localparam int DW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] DB_LAST =
    DW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [DW-1:0]          r_db_cnt;
  logic                   r_stable;
  logic                   r_stable_d;
  logic                   r_press;
  logic                   w_sync;
  logic                   w_rise;
  logic                   w_rpt_fire;

  assign w_sync  = r_sync[SYNC_STAGES-1];
  assign w_rise  = r_stable & ~r_stable_d;
  assign o_press = r_press;

  // Bring the raw pin into the clock domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_btn};
    end
  end

  // Accept a level only after it differs for the full window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_db_cnt <= '0;
      r_stable <= 1'b0;
    end else if (w_sync == r_stable) begin
      r_db_cnt <= '0;
    end else if (r_db_cnt == DB_LAST) begin
      r_stable <= w_sync;
      r_db_cnt <= '0;
    end else begin
      r_db_cnt <= r_db_cnt + DW'(1);
    end
  end

  // Registered strobe on a debounced press or a repeat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stable_d <= 1'b0;
      r_press    <= 1'b0;
    end else begin
      r_stable_d <= r_stable;
      r_press    <= w_rise | w_rpt_fire;
    end
  end

`ifdef BTN_COUNTER_AUTOREPEAT_EN
  if (REPEAT_EN) begin : g_rpt
    localparam int RMAX =
      (REPEAT_DELAY > REPEAT_PERIOD) ?
      REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW = cnt_width(RMAX);
    localparam logic [RW-1:0] RD_LAST =
      RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RP_LAST =
      RW'(REPEAT_PERIOD - 1);

    logic [RW-1:0] r_rpt_cnt;
    logic          r_rpt_first;
    logic          w_rpt_hit;

    // First interval is the long delay, then the period.
    assign w_rpt_hit = r_rpt_first ?
      (r_rpt_cnt == RD_LAST) :
      (r_rpt_cnt == RP_LAST);

    // Counting starts the cycle after the press strobe.
    assign w_rpt_fire =
      r_stable & r_stable_d & w_rpt_hit;

    // Held-button timer; idle whenever released.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_rpt_cnt   <= '0;
        r_rpt_first <= 1'b1;
      end else if (!r_stable) begin
        r_rpt_cnt   <= '0;
        r_rpt_first <= 1'b1;
      end else if (r_stable_d) begin
        if (w_rpt_hit) begin
          r_rpt_cnt   <= '0;
          r_rpt_first <= 1'b0;
        end else begin
          r_rpt_cnt <= r_rpt_cnt + RW'(1);
        end
      end
    end
  end else begin : g_no_rpt
    assign w_rpt_fire = 1'b0;
  end
`else
  assign w_rpt_fire = 1'b0;
`endif

endmodule

// File: rtl/btn_counter.sv
// Debounced up/down/clear LED counter, wrap or saturate.
// Auto-repeat enabled by BTN_COUNTER_AUTOREPEAT_EN.
module btn_counter
  import btn_counter_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE,
  parameter bit SATURATE        = 1'b0,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             btn_clr,
  output logic [WIDTH-1:0] count,
  output logic             up_pulse,
  output logic             down_pulse,
  output logic             limit
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  if (WIDTH < 2) begin : g_bad_width
    $error("btn_counter: WIDTH must be >= 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_db
    $error("btn_counter: DEBOUNCE_CYCLES must be >= 1");
  end
  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1)
  begin : g_bad_rpt
    $error("btn_counter: repeat timing must be >= 1");
  end

  logic             w_up_ev;
  logic             w_dn_ev;
  logic             w_clr_ev;
  ev_e              w_ev;
  logic             w_at_max;
  logic             w_at_min;
  logic [WIDTH-1:0] r_count;
  logic             r_up_pulse;
  logic             r_dn_pulse;
  logic             r_limit;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef BTN_COUNTER_AUTOREPEAT_EN
    ,
    .REPEAT_EN      (1'b1),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_PERIOD  (REPEAT_PERIOD)
`endif
  ) u_up (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_btn  (btn_up),
    .o_press(w_up_ev)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef BTN_COUNTER_AUTOREPEAT_EN
    ,
    .REPEAT_EN      (1'b1),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_PERIOD  (REPEAT_PERIOD)
`endif
  ) u_dn (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_btn  (btn_down),
    .o_press(w_dn_ev)
  );

  // Clear is a single-shot action; it never repeats.
  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef BTN_COUNTER_AUTOREPEAT_EN
    ,
    .REPEAT_EN      (1'b0),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_PERIOD  (REPEAT_PERIOD)
`endif
  ) u_clr (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_btn  (btn_clr),
    .o_press(w_clr_ev)
  );

  assign w_ev     = resolve_ev(w_up_ev, w_dn_ev, w_clr_ev);
  assign w_at_max = (r_count == CNT_MAX);
  assign w_at_min = (r_count == '0);

  // Apply the winning event; pulses clear every other cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count    <= '0;
      r_up_pulse <= 1'b0;
      r_dn_pulse <= 1'b0;
      r_limit    <= 1'b0;
    end else begin
      r_up_pulse <= 1'b0;
      r_dn_pulse <= 1'b0;
      r_limit    <= 1'b0;
      unique case (w_ev)
        EV_CLR: begin
          r_count <= '0;
        end
        EV_UP: begin
          r_up_pulse <= 1'b1;
          if (w_at_max) begin
            r_limit <= 1'b1;
            r_count <= SATURATE ? CNT_MAX : '0;
          end else begin
            r_count <= r_count + CNT_ONE;
          end
        end
        EV_DOWN: begin
          r_dn_pulse <= 1'b1;
          if (w_at_min) begin
            r_limit <= 1'b1;
            r_count <= SATURATE ? '0 : CNT_MAX;
          end else begin
            r_count <= r_count - CNT_ONE;
          end
        end
        EV_NONE: begin
        end
      endcase
    end
  end

  assign count      = r_count;
  assign up_pulse   = r_up_pulse;
  assign down_pulse = r_dn_pulse;
  assign limit      = r_limit;

endmodule

// File: tb/tb_btn_counter.sv
// Bench for btn_counter: wrap and saturate instances side by side.
// Repeat section active with BTN_COUNTER_AUTOREPEAT_EN.
module tb_btn_counter;

  localparam int W    = 4;
  localparam int D    = 4;
  localparam int RD   = 20;
  localparam int RP   = 5;
  localparam int MAXV = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         btn_up;
  logic         btn_down;
  logic         btn_clr;
  logic [W-1:0] cnt_w;
  logic [W-1:0] cnt_s;
  logic         up_w, dn_w, lim_w;
  logic         up_s, dn_s, lim_s;

  int n_tests = 0;
  int n_fail  = 0;
  int m_w     = 0;
  int m_s     = 0;
  bit g_seen;

  always #5 clk = ~clk;

  btn_counter #(
    .WIDTH(W), .DEBOUNCE_CYCLES(D), .SATURATE(1'b0),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut_w (
    .clk(clk), .rst_n(rst_n),
    .btn_up(btn_up), .btn_down(btn_down), .btn_clr(btn_clr),
    .count(cnt_w), .up_pulse(up_w),
    .down_pulse(dn_w), .limit(lim_w)
  );

  btn_counter #(
    .WIDTH(W), .DEBOUNCE_CYCLES(D), .SATURATE(1'b1),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut_s (
    .clk(clk), .rst_n(rst_n),
    .btn_up(btn_up), .btn_down(btn_down), .btn_clr(btn_clr),
    .count(cnt_s), .up_pulse(up_s),
    .down_pulse(dn_s), .limit(lim_s)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    if (up_w | dn_w | lim_w | up_s | dn_s | lim_s)
      g_seen = 1'b1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // pw/ps are {up_pulse, down_pulse, limit}.
  task automatic check_state(input string tag,
                             input int ew, input int es,
                             input logic [2:0] pw,
                             input logic [2:0] ps);
    chk({tag, "/w_cnt"}, 32'(cnt_w), ew);
    chk({tag, "/w_pls"}, 32'({up_w, dn_w, lim_w}), 32'(pw));
    chk({tag, "/s_cnt"}, 32'(cnt_s), es);
    chk({tag, "/s_pls"}, 32'({up_s, dn_s, lim_s}), 32'(ps));
  endtask

  // Counter behaviour stated as arithmetic on integers.
  task automatic ref_step(input bit sat, input int c,
                          input bit up, input bit dn,
                          input bit clr,
                          output int nc, output logic [2:0] p);
    nc = c;
    p  = 3'b000;
    if (clr) begin
      nc = 0;
    end else if (up && !dn) begin
      p[2] = 1'b1;
      p[0] = (c == MAXV);
      nc   = sat ? ((c == MAXV) ? MAXV : c + 1)
                 : (c + 1) % (MAXV + 1);
    end else if (dn && !up) begin
      p[1] = 1'b1;
      p[0] = (c == 0);
      nc   = sat ? ((c == 0) ? 0 : c - 1)
                 : (c + MAXV) % (MAXV + 1);
    end
  endtask

  // Clean press held from just before edge k; effect at edge k+7.
  task automatic press(input bit up, input bit dn,
                       input bit clr, input string tag);
    int nw, ns;
    logic [2:0] pw, ps;
    ref_step(1'b0, m_w, up, dn, clr, nw, pw);
    ref_step(1'b1, m_s, up, dn, clr, ns, ps);
    btn_up   = up;
    btn_down = dn;
    btn_clr  = clr;
    repeat (D + 3) tick();
    check_state({tag, ":pre"}, m_w, m_s, 3'b000, 3'b000);
    tick();
    check_state({tag, ":hit"}, nw, ns, pw, ps);
    tick();
    check_state({tag, ":post"}, nw, ns, 3'b000, 3'b000);
    m_w      = nw;
    m_s      = ns;
    btn_up   = 1'b0;
    btn_down = 1'b0;
    btn_clr  = 1'b0;
    g_seen   = 1'b0;
    repeat (D + 6) tick();
    chk({tag, ":rel_quiet"}, 32'(g_seen), 0);
  endtask

  // Random pulses all shorter than the debounce window.
  task automatic glitch_burst(input string tag);
    int b, n;
    b = $urandom_range(0, 2);
    n = $urandom_range(2, 6);
    g_seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (b == 0) btn_up = 1'b1;
      else if (b == 1) btn_down = 1'b1;
      else btn_clr = 1'b1;
      repeat ($urandom_range(1, D - 1)) tick();
      btn_up   = 1'b0;
      btn_down = 1'b0;
      btn_clr  = 1'b0;
      repeat ($urandom_range(1, 3)) tick();
    end
    repeat (D + 6) tick();
    chk({tag, ":quiet"}, 32'(g_seen), 0);
    chk({tag, ":w_cnt"}, 32'(cnt_w), m_w);
    chk({tag, ":s_cnt"}, 32'(cnt_s), m_s);
  endtask

  initial begin
    rst_n    = 1'b0;
    btn_up   = 1'b0;
    btn_down = 1'b0;
    btn_clr  = 1'b0;
    g_seen   = 1'b0;
    repeat (3) tick();
    check_state("reset", 0, 0, 3'b000, 3'b000);
    rst_n = 1'b1;
    repeat (3) tick();

    press(1'b1, 1'b0, 1'b0, "first_up");

    // Toggle every 2 cycles: never long enough to accept.
    g_seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      btn_up = ~btn_up;
      repeat (2) tick();
    end
    btn_up = 1'b0;
    repeat (D + 6) tick();
    chk("toggle:quiet", 32'(g_seen), 0);
    chk("toggle:w_cnt", 32'(cnt_w), m_w);

    // Limits: 17 ups from 0, then a down from 0.
    press(1'b0, 1'b0, 1'b1, "clr0");
    for (int i = 1; i <= 17; i++)
      press(1'b1, 1'b0, 1'b0, $sformatf("up%0d", i));
    press(1'b0, 1'b0, 1'b1, "clr1");
    press(1'b0, 1'b1, 1'b0, "down_at0");

    // Same-edge combinations at count 9.
    press(1'b0, 1'b0, 1'b1, "clr2");
    for (int i = 0; i < 9; i++)
      press(1'b1, 1'b0, 1'b0, "to9");
    press(1'b1, 1'b1, 1'b0, "up_dn");
    press(1'b1, 1'b0, 1'b1, "clr_up");

    // Reset in the middle of a debounce, button still held.
    for (int i = 0; i < 3; i++)
      press(1'b1, 1'b0, 1'b0, "pre_rst");
    btn_up = 1'b1;
    repeat (2) tick();
    rst_n = 1'b0;
    #1;
    check_state("rst_async", 0, 0, 3'b000, 3'b000);
    m_w = 0;
    m_s = 0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (D + 3) tick();
    check_state("rst_hold:pre", 0, 0, 3'b000, 3'b000);
    tick();
    check_state("rst_hold:hit", 1, 1, 3'b100, 3'b100);
    tick();
    check_state("rst_hold:post", 1, 1, 3'b000, 3'b000);
    repeat (10) tick();
    check_state("rst_hold:once", 1, 1, 3'b000, 3'b000);
    btn_up = 1'b0;
    repeat (D + 6) tick();
    m_w = 1;
    m_s = 1;

    // Random presses mixed with sub-window glitches.
    for (int i = 0; i < 40; i++) begin
      int r;
      r = $urandom_range(0, 7);
      if (r <= 2)
        press(1'b1, 1'b0, 1'b0, $sformatf("rnd%0d_up", i));
      else if (r <= 5)
        press(1'b0, 1'b1, 1'b0, $sformatf("rnd%0d_dn", i));
      else if (r == 6)
        press(1'b0, 1'b0, 1'b1, $sformatf("rnd%0d_clr", i));
      else
        press(1'b1, 1'b1, 1'b0, $sformatf("rnd%0d_both", i));
      if ($urandom_range(0, 3) == 0)
        glitch_burst($sformatf("glitch%0d", i));
    end

`ifdef BTN_COUNTER_AUTOREPEAT_EN
    // Held up: press at k+7, repeats at +RD, then every RP.
    press(1'b0, 1'b0, 1'b1, "rpt_clr");
    btn_up = 1'b1;
    repeat (D + 4) tick();
    check_state("rpt:k+7", 1, 1, 3'b100, 3'b100);
    repeat (RD - 1) tick();
    check_state("rpt:k+26", 1, 1, 3'b000, 3'b000);
    tick();
    check_state("rpt:k+27", 2, 2, 3'b100, 3'b100);
    repeat (2 * RP - 1) tick();
    check_state("rpt:k+36", 3, 3, 3'b000, 3'b000);
    tick();
    check_state("rpt:k+37", 4, 4, 3'b100, 3'b100);
    // Released before k+38: stable stays high through
    // k+42, so the repeat due at k+41 still lands.
    btn_up = 1'b0;
    repeat (20) tick();
    check_state("rpt:final", 5, 5, 3'b000, 3'b000);
    m_w = 5;
    m_s = 5;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
